seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for the 8-digit common-anode 7-segment display. Sits directly
//  downstream of the display channel selector and consumes its seg7_data (32-bit hex),
//  seg7_ascii_data (8 ASCII bytes) and ascii_mode outputs. Latches a tear-free snapshot
//  once per frame, decodes each digit to segment patterns, and scans the anodes with
//  anti-ghosting blanking, decimal points and per-digit blink.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per digit slot (>= BLANK_CYC+2)
//  BLANK_CYC     4      cycles at start of each slot with all anodes off (anti-ghost)
//  BLINK_FRAMES  64     frames per blink half-period (>= 1)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   reset, synchronous, active-high
//  seg7_data       in   32  hex data; digit i shows seg7_data[4i+3:4i]
//  seg7_ascii_data in   64  ASCII data; digit i shows byte [8i+7:8i] (digit 7 leftmost)
//  ascii_mode      in   1   1 = ASCII decode, 0 = hex decode
//  dp_in           in   8   decimal point per digit, active-high
//  blink_mask      in   8   per-digit blink enable, active-high
//  an              out  8   anode enables, active-low, an[i] = digit i
//  seg             out  8   {dp,g,f,e,d,c,b,a}, active-low
//  frame_done      out  1   1-cycle pulse at end of each 8-digit frame
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset: cnt=0, digit=0, blink_phase=0,
//    frame count=0, snapshot regs=0; an=8'hFF, seg=8'hFF, frame_done=0.
//  - Prescaler cnt runs 0..SCAN_DIV-1; tick = (cnt==SCAN_DIV-1). On tick cnt->0, digit
//    increments mod 8 (7 wraps to 0).
//  - Snapshot: in any cycle with cnt==0 && digit==0 (including the first cycle after reset
//    release), seg7_data, seg7_ascii_data, ascii_mode, dp_in and blink_mask are all latched.
//    Input changes at any other time are invisible until the next frame.
//  - an/seg/frame_done are registered and reflect cycle-N state at cycle N+1.
//    cnt < BLANK_CYC: an=8'hFF, seg=8'hFF. Otherwise an=~(8'b1<<digit), seg=glyph of current
//    digit with seg[7]=~dp_snap[digit].
//  - Blink: frame counter counts completed frames 0..BLINK_FRAMES-1; at wrap blink_phase
//    toggles. blink_phase=1 with blink_snap[digit]=1: an stays 8'hFF for that slot.
//  - frame_done: asserted on the cycle after tick with digit==7.
//  - Hex glyphs (active-low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90,
//    A 88, b 83, C C6, d A1, E 86, F 8E (dp bit shown as 1).
//  - ASCII glyphs: '0'-'9' use hex table; 'A'-'Z' and 'a'-'z' map case-insensitively to a
//    fixed best-effort table (A-F match hex; H 89, L C7, o A3, P 8C, r AF, t 87, U C1,
//    y 91); '-' = BF, '_' = F7; space, all other letters/codes, and bytes >= 0x80 are blank (FF).
//  - rst mid-scan: next cycle outputs at reset values; scan restarts at digit 0 with a
//    fresh snapshot.
// TESTING (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
//  1. Hold rst 3 cycles -> an=FF, seg=FF, frame_done=0; first digit-0 slot shows
//     snapshot taken in the first post-reset cycle.
//  2. Hex 32'h0123ABCF, dp_in=0 -> slot 0: 2 cycles an=FF, then an=FE seg=8E; slot 4:
//     an=EF seg=B0; slot 7: an=7F seg=C0; frame_done pulses once per 64 cycles.
//  3. Change seg7_data 32'h0->32'hFFFFFFFF during digit 3 -> digits 3..7 still show 0
//     (C0); digit 0 of next frame shows 8E.
//  4. ascii_mode=1, data "HELLO-01" (byte7='H' ... byte0='1') -> an=7F seg=89; digit 2
//     '-' seg=BF; byte '#' -> seg=FF; dp_in=8'h01 -> digit 0 seg=79.
//  5. blink_mask=8'h01 -> digit 0 visible in frames 0,1, an=FF through slot 0 in
//     frames 2,3, visible again in frames 4,5.
//  6. Assert rst 1 cycle while digit=5, cnt=4 -> next cycle an=FF; the following slot
//     sequence restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver.
// Takes a per-frame snapshot of the inputs, then scans the digits with blanking, decimal points and blink.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg7_data,
  input  logic [63:0] seg7_ascii_data,
  input  logic        ascii_mode,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    digit;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [31:0]   data_snap;
  logic [63:0]   ascii_snap;
  logic          mode_snap;
  logic [7:0]    dp_snap;
  logic [7:0]    blink_snap;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g[6:0];
  endfunction

  function automatic logic [6:0] ascii_glyph(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] g;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    if (u >= 8'h30 && u <= 8'h39) begin
      return hex_glyph(u[3:0]);
    end
    case (u)
      8'h41: g = 8'h88;  8'h42: g = 8'h83;  8'h43: g = 8'hC6;  8'h44: g = 8'hA1;
      8'h45: g = 8'h86;  8'h46: g = 8'h8E;  8'h48: g = 8'h89;  8'h4C: g = 8'hC7;
      8'h4F: g = 8'hA3;  8'h50: g = 8'h8C;  8'h52: g = 8'hAF;  8'h54: g = 8'h87;
      8'h55: g = 8'hC1;  8'h59: g = 8'h91;  8'h2D: g = 8'hBF;  8'h5F: g = 8'hF7;
      default: g = 8'hFF;
    endcase
    return g[6:0];
  endfunction

  logic        tick;
  logic        snap_now;
  logic [31:0] data_eff;
  logic [63:0] ascii_eff;
  logic        mode_eff;
  logic [7:0]  dp_eff;
  logic [7:0]  blink_eff;
  logic [6:0]  glyph;
  logic [7:0]  an_next;
  logic [7:0]  seg_next;

  always_comb begin
    tick     = (cnt == CW'(SCAN_DIV - 1));
    snap_now = (cnt == '0) && (digit == 3'd0);
    // Snapshot cycle decodes from the live inputs so a zero-length blank still sees fresh data
    data_eff  = snap_now ? seg7_data       : data_snap;
    ascii_eff = snap_now ? seg7_ascii_data : ascii_snap;
    mode_eff  = snap_now ? ascii_mode      : mode_snap;
    dp_eff    = snap_now ? dp_in           : dp_snap;
    blink_eff = snap_now ? blink_mask      : blink_snap;
    glyph     = mode_eff ? ascii_glyph(ascii_eff[{digit, 3'b000} +: 8])
                         : hex_glyph(data_eff[{digit, 2'b00} +: 4]);
    an_next   = 8'hFF;
    seg_next  = 8'hFF;
    if (cnt >= CW'(BLANK_CYC)) begin
      seg_next = {~dp_eff[digit], glyph};
      if (!(blink_phase && blink_eff[digit])) begin
        an_next = ~(8'b1 << digit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      digit       <= 3'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      data_snap   <= '0;
      ascii_snap  <= '0;
      mode_snap   <= 1'b0;
      dp_snap     <= '0;
      blink_snap  <= '0;
      an          <= 8'hFF;
      seg         <= 8'hFF;
      frame_done  <= 1'b0;
    end else begin
      if (snap_now) begin
        data_snap  <= seg7_data;
        ascii_snap <= seg7_ascii_data;
        mode_snap  <= ascii_mode;
        dp_snap    <= dp_in;
        blink_snap <= blink_mask;
      end
      if (tick) begin
        cnt   <= '0;
        digit <= digit + 3'd1;
        if (digit == 3'd7) begin
          if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
      an         <= an_next;
      seg        <= seg_next;
      frame_done <= tick && (digit == 3'd7);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a cycle-indexed scoreboard of expected outputs.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg7_data = '0;
  logic [63:0] seg7_ascii_data = '0;
  logic        ascii_mode = 1'b0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  seg7_scan_driver #(
    .SCAN_DIV    (8),
    .BLANK_CYC   (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .seg7_data      (seg7_data),
    .seg7_ascii_data(seg7_ascii_data),
    .ascii_mode     (ascii_mode),
    .dp_in          (dp_in),
    .blink_mask     (blink_mask),
    .an             (an),
    .seg            (seg),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] an;
    logic [7:0] seg;
    bit         chk_seg;
  } item_t;

  item_t q[$];
  int    cyc = -1;   // outputs after the latest edge reflect scan cycle `cyc`
  int    tests = 0;
  int    fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int c, input string tag, input logic [7:0] a, input logic [7:0] s,
                      input bit cs = 1'b1);
    item_t it;
    it.cyc = c; it.tag = tag; it.an = a; it.seg = s; it.chk_seg = cs;
    q.push_back(it);
  endtask

  task automatic drain();
    item_t it;
    logic  fd_exp;
    while (q.size() > 0) begin
      it = q.pop_front();
      if (it.cyc < cyc) begin
        tests++;
        fails++;
        $error("FAIL %s order: at cycle %0d, wanted cycle %0d", it.tag, cyc, it.cyc);
      end
      while (cyc < it.cyc) step();
      fd_exp = (cyc >= 0) && (cyc % 64 == 63);
      tests++;
      assert (an === it.an) else begin
        fails++;
        $error("FAIL %s an: got %h want %h", it.tag, an, it.an);
      end
      if (it.chk_seg) begin
        tests++;
        assert (seg === it.seg) else begin
          fails++;
          $error("FAIL %s seg: got %h want %h", it.tag, seg, it.seg);
        end
      end
      tests++;
      assert (frame_done === fd_exp) else begin
        fails++;
        $error("FAIL %s frame_done: got %b want %b", it.tag, frame_done, fd_exp);
      end
    end
  endtask

  initial begin
    // Reset held 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(-1, "reset", 8'hFF, 8'hFF);
    drain();

    // Hex frame 0; data changes right after the snapshot cycle must be ignored
    seg7_data = 32'h0123ABCF;
    rst = 1'b0;
    push(0, "f0_blank0", 8'hFF, 8'hFF);
    drain();
    seg7_data = 32'h0;
    push(1, "f0_blank1", 8'hFF, 8'hFF);
    push(2, "f0_d0", 8'hFE, 8'h8E);
    push(10, "f0_d1", 8'hFD, 8'hC6);
    push(34, "f0_d4", 8'hEF, 8'hB0);
    push(58, "f0_d7", 8'h7F, 8'hC0);
    push(62, "f0_pre_done", 8'h7F, 8'hC0);
    push(63, "f0_done", 8'h7F, 8'hC0);
    push(64, "f1_post_done", 8'hFF, 8'hFF);
    push(66, "f1_d0", 8'hFE, 8'hC0);
    push(88, "f1_d3_blank", 8'hFF, 8'hFF);
    drain();

    // Mid-frame data change stays hidden until the next frame
    seg7_data = 32'hFFFF_FFFF;
    push(90, "f1_d3", 8'hF7, 8'hC0);
    push(122, "f1_d7", 8'h7F, 8'hC0);
    push(127, "f1_done", 8'h7F, 8'hC0);
    push(130, "f2_d0", 8'hFE, 8'h8E);
    drain();

    // ASCII "HELLO-01" with dp on digit 0
    ascii_mode = 1'b1;
    seg7_ascii_data = "HELLO-01";
    dp_in = 8'h01;
    push(194, "asc_d0_dp", 8'hFE, 8'h79);
    push(202, "asc_d1", 8'hFD, 8'hC0);
    push(210, "asc_dash", 8'hFB, 8'hBF);
    push(218, "asc_O", 8'hF7, 8'hA3);
    push(242, "asc_E", 8'hBF, 8'h86);
    push(250, "asc_H", 8'h7F, 8'h89);
    drain();

    // Unknown punctuation, lowercase letter, high byte
    seg7_ascii_data[7:0]   = "#";
    seg7_ascii_data[15:8]  = "h";
    seg7_ascii_data[23:16] = 8'hC1;
    dp_in = 8'h00;
    push(258, "asc_hash", 8'hFE, 8'hFF);
    push(266, "asc_lower_h", 8'hFD, 8'h89);
    push(274, "asc_hibyte", 8'hFB, 8'hFF);
    drain();

    // Blink digit 0: frames 4,5 phase 0, frames 6,7 phase 1, frames 8,9 phase 0
    ascii_mode = 1'b0;
    seg7_data = 32'h0123ABCF;
    blink_mask = 8'h01;
    push(322, "blink_f5_on", 8'hFE, 8'h8E);
    push(386, "blink_f6_off", 8'hFF, 8'h00, 1'b0);
    push(394, "blink_f6_d1", 8'hFD, 8'hC6);
    push(450, "blink_f7_off", 8'hFF, 8'h00, 1'b0);
    push(514, "blink_f8_on", 8'hFE, 8'h8E);
    push(555, "pre_rst_d5", 8'hDF, 8'hA4);
    drain();

    // Reset mid-scan at digit 5, cnt 4, then a fresh scan with new data
    rst = 1'b1;
    seg7_data = 32'h89AB_CDE7;
    blink_mask = 8'h00;
    push(556, "mid_rst", 8'hFF, 8'hFF);
    drain();
    rst = 1'b0;
    cyc = -1;
    push(0, "rs_blank0", 8'hFF, 8'hFF);
    push(1, "rs_blank1", 8'hFF, 8'hFF);
    push(2, "rs_d0", 8'hFE, 8'hF8);
    push(10, "rs_d1", 8'hFD, 8'h86);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
